// File: rtl/decode_stage_p.sv
// Instruction-decode pipeline stage.
// Splits the fetched instruction into opcode / imm_sel / rs2-imm / rs1-rd
// fields, drives the register-file read indices combinationally and
// captures operands, next PC, control, destination and a sign-extended
// immediate into the ID/EX register. Handles flush, downstream stall,
// load-use hazard bubbles and a saturating bubble counter.
//
// Instruction layout (MSB..LSB):
//   [INST_W-1 -: OPC_W]      opcode
//   [2*ADDR_W]               imm_sel (1 = use immediate instead of rs2)
//   [2*ADDR_W-1 : ADDR_W]    rs2 / immediate field
//   [ADDR_W-1 : 0]           rs1 / rd field
//
// Handshake: valid_if qualifies inst_if/npc_if from fetch. When stall_if is
// high the stage does not consume the offered instruction this cycle and
// fetch must present the same instruction again; stall_ex high means the
// execute stage is not taking ID/EX, so ID/EX holds. flush overrides both
// and turns the entering slot into a bubble.
module decode_stage_p #(
  parameter int               INST_W   = 16,
  parameter int               DATA_W   = 24,
  parameter int               ADDR_W   = 5,
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] LOAD_OPC = 5'b01000,
  parameter logic [OPC_W-1:0] NOP_OPC  = 5'b00000,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] npc_if,
  input  logic [INST_W-1:0] inst_if,
  input  logic              valid_if,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              stall_ex,
  input  logic              flush,
  output logic [ADDR_W-1:0] read_index_1,
  output logic [ADDR_W-1:0] read_index_2,
  output logic              stall_if,
  output logic [INST_W-1:0] npc_id,
  output logic [DATA_W-1:0] reg1_id,
  output logic [DATA_W-1:0] reg2_id,
  output logic [DATA_W-1:0] imm_id,
  output logic              imm_sel_id,
  output logic [OPC_W-1:0]  ctrl_id,
  output logic [ADDR_W-1:0] rd_id,
  output logic              valid_id,
  output logic [CNT_W-1:0]  bubble_count
);

  // The fields must fit in the instruction word and the immediate must be
  // widened, never narrowed.
  if (OPC_W + 2 * ADDR_W + 1 > INST_W) begin : g_bad_format
    $error("decode_stage_p: OPC_W + 2*ADDR_W + 1 exceeds INST_W");
  end
  if (DATA_W <= ADDR_W) begin : g_bad_data_w
    $error("decode_stage_p: DATA_W must be wider than ADDR_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [OPC_W-1:0]  opc;
  logic              imm_sel;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] imm_ext;
  logic              id_is_load;
  logic              src_match;
  logic              hazard;

  // Field extraction and immediate sign extension.
  always_comb begin
    opc     = inst_if[INST_W-1 -: OPC_W];
    imm_sel = inst_if[2*ADDR_W];
    rs2     = inst_if[2*ADDR_W-1:ADDR_W];
    rs1     = inst_if[ADDR_W-1:0];
    imm_ext = {{(DATA_W-ADDR_W){rs2[ADDR_W-1]}}, rs2};
  end

  assign read_index_1 = rs1;
  assign read_index_2 = rs2;

  // Load-use detection: a valid load in ID/EX whose destination is read by
  // the incoming instruction. rs2 only counts when it is a register, not an
  // immediate. Once the bubble drops valid_id the hazard clears by itself,
  // so a load-use pair costs exactly one bubble.
  always_comb begin
    id_is_load = valid_id && (ctrl_id == LOAD_OPC);
    src_match  = (rd_id == rs1) || (!imm_sel && (rd_id == rs2));
    hazard     = id_is_load && valid_if && src_match;
    stall_if   = !flush && (stall_ex || hazard);
  end

  // ID/EX register: priority flush > stall_ex > hazard > normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc_id       <= '0;
      reg1_id      <= '0;
      reg2_id      <= '0;
      imm_id       <= '0;
      imm_sel_id   <= 1'b0;
      ctrl_id      <= NOP_OPC;
      rd_id        <= '0;
      valid_id     <= 1'b0;
      bubble_count <= '0;
    end else if (flush) begin
      valid_id <= 1'b0;
      ctrl_id  <= NOP_OPC;
    end else if (stall_ex) begin
      valid_id <= valid_id;
    end else if (hazard) begin
      valid_id <= 1'b0;
      ctrl_id  <= NOP_OPC;
      if (bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + CNT_ONE;
      end
    end else begin
      npc_id     <= npc_if;
      reg1_id    <= read_data_1;
      reg2_id    <= read_data_2;
      imm_id     <= imm_ext;
      imm_sel_id <= imm_sel;
      ctrl_id    <= opc;
      rd_id      <= rs1;
      valid_id   <= valid_if;
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed scenarios plus a
// randomized run checked against a behavioural model of the ID/EX slot.
// A second instance with a 2-bit counter exercises saturation.
module tb_decode_stage_p;

  localparam logic [4:0] LOAD = 5'b01000;
  localparam logic [4:0] NOP  = 5'b00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [15:0] npc_if, inst_if;
  logic        valid_if, stall_ex, flush;
  logic [23:0] read_data_1, read_data_2;
  logic [4:0]  read_index_1, read_index_2;
  logic        stall_if;
  logic [15:0] npc_id;
  logic [23:0] reg1_id, reg2_id, imm_id;
  logic        imm_sel_id;
  logic [4:0]  ctrl_id, rd_id;
  logic        valid_id;
  logic [15:0] bubble_count;

  logic [4:0]  s_read_index_1, s_read_index_2;
  logic        s_stall_if;
  logic [15:0] s_npc_id;
  logic [23:0] s_reg1_id, s_reg2_id, s_imm_id;
  logic        s_imm_sel_id;
  logic [4:0]  s_ctrl_id, s_rd_id;
  logic        s_valid_id;
  logic [1:0]  s_bubble_count;

  decode_stage_p dut (
    .clk(clk), .rst_n(rst_n), .npc_if(npc_if), .inst_if(inst_if),
    .valid_if(valid_if), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .stall_ex(stall_ex), .flush(flush), .read_index_1(read_index_1),
    .read_index_2(read_index_2), .stall_if(stall_if), .npc_id(npc_id),
    .reg1_id(reg1_id), .reg2_id(reg2_id), .imm_id(imm_id),
    .imm_sel_id(imm_sel_id), .ctrl_id(ctrl_id), .rd_id(rd_id),
    .valid_id(valid_id), .bubble_count(bubble_count)
  );

  decode_stage_p #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .npc_if(npc_if), .inst_if(inst_if),
    .valid_if(valid_if), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .stall_ex(stall_ex), .flush(flush), .read_index_1(s_read_index_1),
    .read_index_2(s_read_index_2), .stall_if(s_stall_if), .npc_id(s_npc_id),
    .reg1_id(s_reg1_id), .reg2_id(s_reg2_id), .imm_id(s_imm_id),
    .imm_sel_id(s_imm_sel_id), .ctrl_id(s_ctrl_id), .rd_id(s_rd_id),
    .valid_id(s_valid_id), .bubble_count(s_bubble_count)
  );

  int checks = 0;
  int passed = 0;

  // ---------------- behavioural model ----------------
  logic [15:0] m_npc;
  logic [23:0] m_r1, m_r2, m_imm;
  logic        m_sel, m_valid;
  logic [4:0]  m_ctrl, m_rd;
  int          m_bubbles;

  function automatic int f_rs1(input logic [15:0] i);  return int'(i) % 32;        endfunction
  function automatic int f_rs2(input logic [15:0] i);  return (int'(i) / 32) % 32; endfunction
  function automatic int f_sel(input logic [15:0] i);  return (int'(i) / 1024) % 2; endfunction
  function automatic int f_opc(input logic [15:0] i);  return int'(i) / 2048;      endfunction

  function automatic logic [23:0] f_imm(input logic [15:0] i);
    int v;
    v = f_rs2(i);
    if (v >= 16) v = v - 32;
    return 24'(v);
  endfunction

  function automatic logic model_hazard();
    return m_valid && (m_ctrl == LOAD) && valid_if &&
           ((int'(m_rd) == f_rs1(inst_if)) ||
            (f_sel(inst_if) == 0 && int'(m_rd) == f_rs2(inst_if)));
  endfunction

  function automatic logic model_stall_if();
    return !flush && (stall_ex || model_hazard());
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (m_bubbles > 3) ? 2'd3 : 2'(m_bubbles);
  endfunction

  function automatic logic [103:0] model_regs();
    return {m_npc, m_r1, m_r2, m_imm, m_sel, m_ctrl, m_rd, m_valid, 1'b0};
  endfunction

  function automatic logic [103:0] dut_regs();
    return {npc_id, reg1_id, reg2_id, imm_id, imm_sel_id, ctrl_id, rd_id, valid_id, 1'b0};
  endfunction

  task automatic model_reset();
    m_npc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_sel = 1'b0;
    m_ctrl = NOP; m_rd = '0; m_valid = 1'b0; m_bubbles = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] inst, input logic [15:0] npc,
                       input logic [23:0] d1, input logic [23:0] d2, input logic v);
    inst_if = inst; npc_if = npc; read_data_1 = d1; read_data_2 = d2; valid_if = v;
  endtask

  // One clock edge; the model steps with the inputs present before it.
  task automatic tick();
    logic hz;
    hz = model_hazard();
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0; m_ctrl = NOP;
    end else if (stall_ex) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 1'b0; m_ctrl = NOP; m_bubbles++;
    end else begin
      m_npc = npc_if; m_r1 = read_data_1; m_r2 = read_data_2;
      m_imm = f_imm(inst_if); m_sel = (f_sel(inst_if) == 1);
      m_ctrl = 5'(f_opc(inst_if)); m_rd = 5'(f_rs1(inst_if)); m_valid = valid_if;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stall_ex = 1'b0; flush = 1'b0;
    drive(16'h0, 16'h0, 24'h0, 24'h0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    drive(16'h17E1, 16'h1234, 24'hABCDEF, 24'h123456, 1'b1);
    tick();
    // Assert reset between edges with random inputs; must clear at once.
    #2;
    drive(16'($urandom), 16'($urandom), 24'($urandom), 24'($urandom), 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({npc_id, reg1_id, reg2_id, imm_id, imm_sel_id, valid_id} !== '0) begin
      $display("FAIL reset_fields: got %h required 0",
               {npc_id, reg1_id, reg2_id, imm_id, imm_sel_id, valid_id});
    end else passed++;
    checks++;
    if (ctrl_id !== NOP || rd_id !== 5'd0) $display("FAIL reset_ctrl_rd: got %h/%h required %h/0", ctrl_id, rd_id, NOP);
    else passed++;
    checks++;
    if (bubble_count !== 16'd0 || s_bubble_count !== 2'd0) $display("FAIL reset_count: got %h/%h required 0/0", bubble_count, s_bubble_count);
    else passed++;
    checks++;
    if (read_index_1 !== 5'(f_rs1(inst_if)) || read_index_2 !== 5'(f_rs2(inst_if)))
      $display("FAIL reset_comb_live: got %h/%h required %h/%h", read_index_1, read_index_2, f_rs1(inst_if), f_rs2(inst_if));
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    do_reset();
    drive(16'h0864, 16'h0011, 24'h000011, 24'h000022, 1'b1);
    #1;
    checks++;
    if (read_index_1 !== 5'd4 || read_index_2 !== 5'd3) $display("FAIL normal_index: got %0d/%0d required 4/3", read_index_1, read_index_2);
    else passed++;
    tick();
    checks++;
    if ({ctrl_id, rd_id, reg1_id, reg2_id, npc_id, imm_sel_id, valid_id} !==
        {5'd1, 5'd4, 24'h000011, 24'h000022, 16'h0011, 1'b0, 1'b1})
      $display("FAIL normal_capture: got ctrl=%h rd=%h r1=%h r2=%h npc=%h sel=%b v=%b required 1 4 11 22 0011 0 1",
               ctrl_id, rd_id, reg1_id, reg2_id, npc_id, imm_sel_id, valid_id);
    else passed++;
  endtask

  task automatic test_immediate();
    drive(16'h17E1, 16'h0012, 24'h000033, 24'h000044, 1'b1);
    tick();
    checks++;
    if ({ctrl_id, imm_sel_id, imm_id, rd_id} !== {5'd2, 1'b1, 24'hFFFFFF, 5'd1})
      $display("FAIL immediate: got ctrl=%h sel=%b imm=%h rd=%h required 2 1 ffffff 1", ctrl_id, imm_sel_id, imm_id, rd_id);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(16'h4043, 16'h0020, 24'h000001, 24'h000002, 1'b1);
    #1;
    checks++;
    if (stall_if !== 1'b0) $display("FAIL load_use_pre: got stall_if=%b required 0", stall_if);
    else passed++;
    tick();
    drive(16'h0864, 16'h0021, 24'h000011, 24'h000022, 1'b1);
    #1;
    checks++;
    if (stall_if !== 1'b1) $display("FAIL load_use_stall: got stall_if=%b required 1", stall_if);
    else passed++;
    tick();
    checks++;
    if (valid_id !== 1'b0 || ctrl_id !== 5'd0 || bubble_count !== 16'd1)
      $display("FAIL load_use_bubble: got v=%b ctrl=%h cnt=%0d required 0 0 1", valid_id, ctrl_id, bubble_count);
    else passed++;
    checks++;
    if (stall_if !== 1'b0) $display("FAIL load_use_release: got stall_if=%b required 0", stall_if);
    else passed++;
    tick();
    checks++;
    if (ctrl_id !== 5'd1 || valid_id !== 1'b1 || bubble_count !== 16'd1)
      $display("FAIL load_use_after: got ctrl=%h v=%b cnt=%0d required 1 1 1", ctrl_id, valid_id, bubble_count);
    else passed++;
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    drive(16'h4043, 16'h0030, 24'h0, 24'h0, 1'b1);
    tick();
    drive(16'h1461, 16'h0031, 24'h0, 24'h0, 1'b1);
    #1;
    checks++;
    if (stall_if !== 1'b0) $display("FAIL no_false_stall: got stall_if=%b required 0", stall_if);
    else passed++;
    tick();
    checks++;
    if (bubble_count !== 16'd0 || valid_id !== 1'b1 || ctrl_id !== 5'd2)
      $display("FAIL no_false_capture: got cnt=%0d v=%b ctrl=%h required 0 1 2", bubble_count, valid_id, ctrl_id);
    else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    drive(16'h0864, 16'h0011, 24'h000011, 24'h000022, 1'b1);
    tick();
    stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 24'($urandom), 24'($urandom), 1'b1);
      #1;
      checks++;
      if (stall_if !== 1'b1) $display("FAIL stall_ex_stall_if: got %b required 1", stall_if);
      else passed++;
      tick();
      checks++;
      if ({ctrl_id, rd_id, reg1_id, reg2_id, npc_id, valid_id} !==
          {5'd1, 5'd4, 24'h000011, 24'h000022, 16'h0011, 1'b1})
        $display("FAIL stall_ex_hold: got ctrl=%h rd=%h r1=%h r2=%h npc=%h v=%b required 1 4 11 22 0011 1",
                 ctrl_id, rd_id, reg1_id, reg2_id, npc_id, valid_id);
      else passed++;
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall_if !== 1'b0) $display("FAIL flush_stall_if: got %b required 0", stall_if);
    else passed++;
    tick();
    checks++;
    if (valid_id !== 1'b0 || ctrl_id !== NOP || rd_id !== 5'd4 || npc_id !== 16'h0011)
      $display("FAIL flush_result: got v=%b ctrl=%h rd=%h npc=%h required 0 0 4 0011", valid_id, ctrl_id, rd_id, npc_id);
    else passed++;
    flush = 1'b0; stall_ex = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int h = 0; h < 5; h++) begin
      drive(16'h4043, 16'h0040, 24'h0, 24'h0, 1'b1);
      tick();
      drive(16'h0864, 16'h0041, 24'h0, 24'h0, 1'b1);
      tick();
      tick();
    end
    checks++;
    if (s_bubble_count !== 2'd3) $display("FAIL saturation_small: got %0d required 3", s_bubble_count);
    else passed++;
    checks++;
    if (bubble_count !== 16'd5) $display("FAIL saturation_wide: got %0d required 5", bubble_count);
    else passed++;
  endtask

  task automatic test_reset_mid_hazard();
    do_reset();
    drive(16'h4043, 16'h0050, 24'h0, 24'h0, 1'b1);
    tick();
    drive(16'h0864, 16'h0051, 24'h000011, 24'h000022, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (valid_id !== 1'b0 || ctrl_id !== NOP || rd_id !== 5'd0 || stall_if !== 1'b0)
      $display("FAIL reset_mid_hazard: got v=%b ctrl=%h rd=%h stall_if=%b required 0 0 0 0", valid_id, ctrl_id, rd_id, stall_if);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (ctrl_id !== 5'd1 || valid_id !== 1'b1 || reg1_id !== 24'h000011)
      $display("FAIL reset_first_capture: got ctrl=%h v=%b r1=%h required 1 1 000011", ctrl_id, valid_id, reg1_id);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] inst;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      inst = 16'($urandom);
      if ($urandom_range(0, 2) == 0) inst = {LOAD, inst[10:0]};
      inst[9:5] = 5'($urandom_range(0, 3));
      inst[4:0] = 5'($urandom_range(0, 3));
      drive(inst, 16'($urandom), 24'($urandom), 24'($urandom), $urandom_range(0, 9) != 0);
      stall_ex = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      #1;
      checks++;
      if ({read_index_1, read_index_2, stall_if} !==
          {5'(f_rs1(inst_if)), 5'(f_rs2(inst_if)), model_stall_if()})
        $display("FAIL random_comb[%0d]: got %h/%h/%b required %h/%h/%b", n, read_index_1, read_index_2, stall_if,
                 f_rs1(inst_if), f_rs2(inst_if), model_stall_if());
      else passed++;
      tick();
      checks++;
      if (dut_regs() !== model_regs())
        $display("FAIL random_regs[%0d]: got %h required %h", n, dut_regs(), model_regs());
      else passed++;
      checks++;
      if (bubble_count !== exp_cnt16() || s_bubble_count !== exp_cnt2() || s_valid_id !== m_valid)
        $display("FAIL random_count[%0d]: got %0d/%0d/%b required %0d/%0d/%b", n, bubble_count, s_bubble_count,
                 s_valid_id, exp_cnt16(), exp_cnt2(), m_valid);
      else passed++;
    end
    stall_ex = 1'b0; flush = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    stall_ex = 1'b0; flush = 1'b0;
    drive(16'h0, 16'h0, 24'h0, 24'h0, 1'b0);
    model_reset();
    test_reset();
    test_normal();
    test_immediate();
    test_load_use();
    test_no_false_hazard();
    test_priority();
    test_saturation();
    test_reset_mid_hazard();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parameterised instruction-decode pipeline stage for the pipelined core. It drives register-file read indices, latches operands, next PC, control opcode, destination register and a sign-extended immediate into the ID/EX register. It adds a valid bit, flush, downstream-stall hold, load-use hazard detection with bubble insertion, and a saturating bubble counter.

Parameters:
INST_W, 16, instruction and PC width
DATA_W, 24, register data width
ADDR_W, 5, register index width
OPC_W, 5, opcode width
LOAD_OPC, 5'b01000, opcode treated as a load for hazard detection
NOP_OPC, 5'b00000, opcode written into ctrl_id on a bubble
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
npc_if  in  INST_W  next PC from fetch
inst_if  in  INST_W  instruction from fetch
valid_if  in  1  fetch output valid
read_data_1  in  DATA_W  regfile data for read_index_1
read_data_2  in  DATA_W  regfile data for read_index_2
stall_ex  in  1  downstream cannot accept; hold ID/EX
flush  in  1  squash the instruction entering ID/EX (branch taken)
read_index_1  out  ADDR_W  inst_if[ADDR_W-1:0] (rs1/rd), combinational
read_index_2  out  ADDR_W  inst_if[2*ADDR_W-1:ADDR_W] (rs2/imm), combinational
stall_if  out  1  fetch must hold PC/instruction, combinational
npc_id  out  INST_W  registered next PC
reg1_id  out  DATA_W  registered operand A
reg2_id  out  DATA_W  registered operand B (register value, not the immediate)
imm_id  out  DATA_W  sign-extended inst_if[2*ADDR_W-1:ADDR_W]
imm_sel_id  out  1  registered inst_if[2*ADDR_W]; 1 = use immediate
ctrl_id  out  OPC_W  registered inst_if[INST_W-1:INST_W-OPC_W]
rd_id  out  ADDR_W  registered destination = rs1 field
valid_id  out  1  ID/EX holds a real instruction
bubble_count  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Instruction format: opcode in the top OPC_W bits; bit 2*ADDR_W is imm_sel; the rs2/imm field sits above the rs1/rd field. Elaboration requires OPC_W+2*ADDR_W+1 <= INST_W.
- Reset (rst_n=0, async): all registered outputs are 0, ctrl_id = NOP_OPC and bubble_count = 0. Combinational outputs stay live.
- hazard = valid_id & (ctrl_id==LOAD_OPC) & valid_if & ((rd_id==rs1) | (~imm_sel & rd_id==rs2)), where rs1, rs2 and imm_sel are fields of inst_if.
- stall_if = ~flush & (stall_ex | hazard).
- Per-edge priority is flush > stall_ex > hazard > normal:
  - flush: valid_id<=0 and ctrl_id<=NOP_OPC; other fields hold; counter unchanged.
  - stall_ex: all ID/EX registers hold, valid_id included; counter unchanged.
  - hazard: bubble, so valid_id<=0 and ctrl_id<=NOP_OPC; other fields hold; bubble_count increments and saturates at all-ones.
  - normal: capture all fields; valid_id<=valid_if.
- Latency: one cycle from inst_if to the *_id outputs. A load-use pair costs exactly one bubble, because the hazard clears once valid_id drops.
- imm_id is sign-extended from ADDR_W bits to DATA_W. It is captured regardless of imm_sel.
- valid_if=0 under normal flow: fields are captured, valid_id<=0, and no hazard is raised.
- Reset asserted mid-stall or mid-hazard returns all state to reset values immediately. The first instruction after deassertion captures normally.

Test Plan:
- Reset: rst_n=0 with random inputs -> all *_id=0, valid_id=0, bubble_count=0, asynchronously before the next clk edge.
- Normal ALU op: inst_if=0x0864, read_data_1=0x000011, read_data_2=0x000022, npc_if=0x0011, valid_if=1. Required response:
  - read_index_1=4, read_index_2=3 combinationally.
  - Next cycle ctrl_id=1, rd_id=4, reg1_id=0x000011, reg2_id=0x000022, npc_id=0x0011, imm_sel_id=0, valid_id=1.
- Immediate: inst_if=0x17E1 -> ctrl_id=2, imm_sel_id=1, imm_id=0xFFFFFF, rd_id=1.
- Load-use: load 0x4043 (r3) then 0x0864 (reads r3). Required response:
  - stall_if=1 for exactly one cycle; bubble_count 0->1.
  - Bubble cycle: valid_id=0, ctrl_id=0.
  - Next cycle: ctrl_id=1, valid_id=1.
- No false hazard: load 0x4043 then 0x1461 (imm_sel=1, imm field=3, rs1=1) -> stall_if stays 0 and bubble_count stays 0.
- Priority: stall_ex=1 for 3 cycles -> outputs hold and stall_if=1; then flush=1 with stall_ex=1 -> valid_id=0 and stall_if=0. Saturation: force CNT_W=2 and create 5 hazards -> bubble_count=3.
